stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised, registered N-channel data multiplexer with per-channel valid/ready handshake; successor to the plain 8-bit 2:1 combinational mux.
- Two selection modes: fixed, where an external select picks the channel, and round-robin arbitration across all requesting channels.
- Sits between multiple producers (ALU result, memory read, I/O port) and a single consumer bus in the microcontroller datapath.
- Single output register stage: one beat buffered, full throughput.

Parameters:
WIDTH, 8, data width per channel in bits
NCH, 4, number of input channels (2..16)
SELW, 2, width of select and channel-ID fields; must be >= clog2(NCH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_data  input  NCH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  channel i has a beat
in_ready  output  NCH  channel i beat accepted this cycle
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel index used in fixed mode
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  index of the channel that supplied out_data
out_valid  output  1  out_data holds a beat
out_ready  input  1  consumer accepts the beat

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0. in_ready=0 while rst=1.
- load_en = !out_valid || out_ready (register empty or draining this cycle).
- Grant, combinational:
  - mode=0: grant_ch=sel. grant_vld = (sel < NCH) && in_valid[sel]. An out-of-range sel never grants.
  - mode=1: grant_ch is the first i with in_valid[i]=1, scanning ptr, ptr+1, ... modulo NCH. grant_vld = |in_valid.
- in_ready[i] = !rst && load_en && grant_vld && (i == grant_ch). At most one bit is set. in_ready does not depend on in_valid of other channels beyond the grant.
- Transfer when load_en && grant_vld: next cycle out_data = channel grant_ch data, out_ch = grant_ch, out_valid = 1.
- If out_valid && out_ready and there is no new grant: out_valid goes to 0. out_data and out_ch hold their last values.
- Latency: accepted beat appears on the output 1 cycle after acceptance.
- Throughput: 1 beat/cycle when out_ready is held high.
- Backpressure: out_valid && !out_ready drives every in_ready to 0; out_data and out_ch stay stable until accepted.
- Pointer update:
  - Only on a transfer in mode=1: ptr <= (grant_ch == NCH-1) ? 0 : grant_ch+1.
  - In mode=0, ptr holds its value.
- Mode or sel change: takes effect in the grant of the same cycle. A beat already in the register is unaffected.
- Simultaneous drain and load: output is replaced in one cycle with no bubble.
- Reset mid-operation: the buffered beat is discarded and ptr returns to 0.

Test Plan:
- Reset then idle: out_valid=0, out_data=0, out_ch=0, in_ready=0000 on every cycle with all in_valid=0.
- Fixed mode: mode=0, sel=2, in_valid=1111, in_data ch2=8'hA5, out_ready=1 -> in_ready=0100; next cycle out_data=A5, out_ch=2, out_valid=1. sel=5 with NCH=4 -> in_ready=0000.
- Round-robin fairness: mode=1, all in_valid=1 with ch i data = 8'h10+i, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 and out_data 10,11,12,13,10,... with no gaps.
- Skip and wrap: mode=1, ptr=3, in_valid=0010 -> grant ch1, ptr becomes 2. Then in_valid=1001 -> grant ch3, then ptr=0 -> grant ch0.
- Backpressure: hold out_ready=0 after a beat is loaded (ch1, 8'h3C) -> out_data=3C stable and in_ready=0000 for 5 cycles. Release -> drain and load the next beat in the same cycle.
- Reset mid-stream: assert rst while out_valid=1, ptr=2 -> next cycle out_valid=0, ptr=0. The first grant after reset goes to the lowest valid channel.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux, fixed-select or round-robin; accepted beat appears 1 cycle later.
// Full throughput; a held output beat (out_valid && !out_ready) deasserts every in_ready.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_next;
    logic             load_en;
    logic             xfer;

    logic             fix_vld;
    logic             rr_vld;
    logic [SELW-1:0]  rr_ch;
    logic             grant_vld;
    logic [SELW-1:0]  grant_ch;
    logic [WIDTH-1:0] grant_dat;

    assign load_en = !out_valid || out_ready;

    // Fixed select: loop compare keeps an out-of-range sel from ever indexing in_valid.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(sel) == i) begin
                fix_vld = in_valid[i];
            end
        end
    end

    // Round-robin: first requester at or after ptr, wrapping modulo NCH.
    always_comb begin
        int idx;
        rr_vld = 1'b0;
        rr_ch  = ptr;
        idx    = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            for (int i = 0; i < NCH; i++) begin
                if (!rr_vld && i == idx && in_valid[i]) begin
                    rr_vld = 1'b1;
                    rr_ch  = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_vld = mode ? rr_vld : fix_vld;
        grant_ch  = mode ? rr_ch  : sel;
    end

    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(grant_ch) == i) begin
                grant_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = load_en && grant_vld;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = !rst && xfer && (int'(grant_ch) == i);
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (xfer && mode) begin
            if (int'(grant_ch) == NCH - 1) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_ch + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            ptr <= ptr_next;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_dat;
                out_ch    <= grant_ch;
            end else if (load_en) begin
                // Drained with nothing to replace it: data/ch keep their last value.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (NCH=4, WIDTH=8, SELW=3 so an out-of-range sel is expressible).
module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 3;

    logic                 clk;
    logic                 rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int total;
    int bad;

    stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] c);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out_data"},  32'(out_data),  32'(d));
        chk({tag, ".out_ch"},    32'(out_ch),    32'(c));
    endtask

    task automatic set_ch(input int ch, input logic [7:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 4'b1111;
        mode      = 1'b1;
        sel       = '0;
        out_ready = 1'b1;

        // Reset: in_ready gated even with every channel requesting.
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        chk_out("rst", 1'b0, 8'h00, 3'd0);
        chk("rst.in_ready2", 32'(in_ready), 32'h0);

        // Idle after reset.
        rst      = 1'b0;
        in_valid = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle.in_ready", 32'(in_ready), 32'h0);
            tick();
            chk_out("idle", 1'b0, 8'h00, 3'd0);
        end

        // Fixed mode, sel=2.
        mode     = 1'b0;
        sel      = 3'd2;
        in_valid = 4'b1111;
        set_ch(0, 8'h11);
        set_ch(1, 8'h22);
        set_ch(2, 8'hA5);
        set_ch(3, 8'h44);
        #1;
        chk("fix.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("fix", 1'b1, 8'hA5, 3'd2);

        // Out-of-range sel never grants; register drains and holds data/ch.
        sel = 3'd5;
        #1;
        chk("fix_oor.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("fix_oor", 1'b0, 8'hA5, 3'd2);

        // Round-robin fairness from ptr=0, no gaps.
        mode = 1'b1;
        for (int c = 0; c < NCH; c++) set_ch(c, 8'(8'h10 + c));
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr.in_ready", 32'(in_ready), 32'(1 << (k % 4)));
            tick();
            chk_out("rr", 1'b1, 8'(8'h10 + (k % 4)), 3'(k % 4));
        end

        // Move ptr to 3 via a grant on ch2.
        in_valid = 4'b0100;
        #1;
        chk("wrap_setup.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("wrap_setup", 1'b1, 8'h12, 3'd2);

        // ptr=3, only ch1 valid -> skip to ch1, ptr becomes 2.
        in_valid = 4'b0010;
        #1;
        chk("skip.in_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("skip", 1'b1, 8'h11, 3'd1);

        // ptr=2, ch0 and ch3 valid -> ch3, then ptr=0 -> ch0.
        in_valid = 4'b1001;
        #1;
        chk("wrap1.in_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("wrap1", 1'b1, 8'h13, 3'd3);
        #1;
        chk("wrap2.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("wrap2", 1'b1, 8'h10, 3'd0);

        // Backpressure: load ch1=3C, then hold out_ready low.
        mode     = 1'b0;
        sel      = 3'd1;
        in_valid = 4'b0010;
        set_ch(1, 8'h3C);
        set_ch(2, 8'h5A);
        tick();
        chk_out("bp_load", 1'b1, 8'h3C, 3'd1);
        out_ready = 1'b0;
        sel       = 3'd2;
        in_valid  = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp.in_ready", 32'(in_ready), 32'h0);
            tick();
            chk_out("bp", 1'b1, 8'h3C, 3'd1);
        end
        // Release: drain and load in the same cycle.
        out_ready = 1'b1;
        #1;
        chk("bp_rel.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("bp_rel", 1'b1, 8'h5A, 3'd2);

        // Reset mid-stream with out_valid=1 and ptr=2.
        mode     = 1'b1;
        in_valid = 4'b0010;
        tick();
        chk_out("mid_setup", 1'b1, 8'h3C, 3'd1);
        rst      = 1'b1;
        in_valid = 4'b1010;
        #1;
        chk("mid_rst.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("mid_rst", 1'b0, 8'h00, 3'd0);
        rst = 1'b0;
        // ptr back at 0: lowest valid (ch1) wins, not ch3.
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("post_rst", 1'b1, 8'h3C, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
